// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the fetch stage.
//   PC_STEP     - byte increment between sequential instructions
//   FETCH_DEPTH - number of fetched words the stage may hold or have in flight
//   NOP_INSTR   - canonical RV32 NOP (addi x0, x0, 0)
//   FETCH_PC_W  - width of the pc field carried in a buffer entry; the
//                 fetch_unit ADDR_W parameter must not exceed it
//   fetch_entry_t - one captured instruction together with its byte address
package fetch_pkg;

  localparam int PC_STEP     = 4;
  localparam int FETCH_DEPTH = 2;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int FETCH_PC_W  = 8;

  typedef struct packed {
    logic [31:0]           instr;
    logic [FETCH_PC_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: 2-entry in-order FIFO of fetch_entry_t.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   push        - write push_entry at the tail this cycle
//   pop         - retire the head entry this cycle (only while count != 0)
//   flush       - drop all entries; wins over push and pop
//   push_entry  - entry to write
//   head        - oldest entry (contents meaningless while count == 0)
//   count       - number of valid entries, 0..2
module fetch_buf
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_entry,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t entries [FETCH_DEPTH];
  logic         rd_ptr;
  logic         wr_ptr;

  // When full, wr_ptr equals rd_ptr; a simultaneous push and pop overwrites
  // the slot being retired, which is safe because head is read combinationally
  // during the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FETCH_DEPTH; i++) begin
        entries[i] <= '0;
      end
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        entries[wr_ptr] <= push_entry;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = entries[rd_ptr];

  // The upstream credit rule must never let the FIFO overflow or underflow.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && !flush && count == 2'd2));
  a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && !flush && count == 2'd0));

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: program counter and fetch control in front of a synchronous
// IMEM with one cycle of read latency.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   imem_addr       - registered byte address presented to IMEM (always the pc)
//   imem_data       - IMEM word for the address presented the previous cycle
//   redirect_valid  - load redirect_pc and flush all younger fetched work
//   redirect_pc     - redirect target, low two bits forced to zero
//   out_valid/out_ready - handshake towards decode
//   out_instr/out_pc    - head instruction and its byte address
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = FETCH_PC_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_pc;
  logic              inflight;
  logic [1:0]        count;
  logic              pop;
  logic              push;
  logic              issue;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;

  assign pop = out_valid & out_ready;

  // Credit check: buffered + in-flight words after this cycle's pop must stay
  // below the buffer depth. Written as a sum comparison to avoid underflow.
  assign issue = !redirect_valid &&
                 (({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

  // A response is only kept if its read was issued and no redirect is
  // discarding it this cycle.
  assign push = inflight & ~redirect_valid;

  always_comb begin
    push_entry       = '0;
    push_entry.instr = imem_data;
    push_entry.pc    = FETCH_PC_W'(req_pc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
    end else if (redirect_valid) begin
      pc       <= {redirect_pc[ADDR_W-1:2], 2'b00};
      inflight <= 1'b0;
    end else if (issue) begin
      pc       <= pc + ADDR_W'(PC_STEP);
      req_pc   <= pc;
      inflight <= 1'b1;
    end else begin
      inflight <= 1'b0;
    end
  end

  fetch_buf u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .pop        (pop),
    .flush      (redirect_valid),
    .push_entry (push_entry),
    .head       (head),
    .count      (count)
  );

  assign imem_addr = pc;
  assign out_valid = (count != 2'd0);
  assign out_instr = head.instr;
  assign out_pc    = ADDR_W'(head.pc);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit. The reference model is
// the architectural delivery order: a stream of PCs starting at the reset PC
// (or the last redirect target) and stepping by 4, each carrying the IMEM
// word at that address.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [7:0]  out_pc;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [64];

  logic        obs_valid;
  logic [7:0]  obs_pc;
  logic [31:0] obs_instr;
  logic [7:0]  obs_addr;

  fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Synchronous IMEM: returns the word for last cycle's address.
  always @(posedge clk) imem_data <= mem[imem_addr[7:2]];

  // Observe the current cycle's outputs at the falling edge, then drive the
  // inputs that apply to this same cycle.
  task automatic tick(input logic rdy, input logic rv, input logic [7:0] rp);
    @(negedge clk);
    obs_valid      = out_valid;
    obs_pc         = out_pc;
    obs_instr      = out_instr;
    obs_addr       = imem_addr;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rp;
  endtask

  // Hold reset for two cycles and release it on a falling edge; the cycle
  // following release is cycle 0, so the first tick observes cycle 1.
  task automatic restart(input logic rdy);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    out_ready      = rdy;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] word_at(input logic [7:0] a);
    return mem[a[7:2]];
  endfunction

  // Reset values are visible while reset is asserted, before any clock.
  task automatic test_reset;
    #1;
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 8'h00 || out_pc !== 8'h00 || out_instr !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_values: got valid=%0b addr=%h pc=%h instr=%h, expected 0/00/00/00000000",
               out_valid, imem_addr, out_pc, out_instr);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_hold: got valid=%0b addr=%h, expected 0/00", out_valid, imem_addr);
    end
  endtask

  // Sequential fetch with decode always ready.
  task automatic test_stream;
    restart(1'b1);
    tick(1'b1, 1'b0, 8'h00);
    checks++;
    if (obs_valid !== 1'b0 || obs_addr !== 8'h04) begin
      errors++;
      $display("[TB] FAIL stream_cycle1: got valid=%0b addr=%h, expected valid=0 addr=04", obs_valid, obs_addr);
    end
    for (int i = 0; i < 10; i++) begin
      logic [7:0] e;
      e = 8'(4 * i);
      tick(1'b1, 1'b0, 8'h00);
      checks++;
      if (obs_valid !== 1'b1 || obs_pc !== e || obs_instr !== word_at(e)) begin
        errors++;
        $display("[TB] FAIL stream_seq%0d: got valid=%0b pc=%h instr=%h, expected valid=1 pc=%h instr=%h",
                 i, obs_valid, obs_pc, obs_instr, e, word_at(e));
      end
    end
  endtask

  // Decode stalls for 5 cycles from the first valid output.
  task automatic test_stall;
    restart(1'b0);
    tick(1'b0, 1'b0, 8'h00);
    for (int c = 2; c <= 6; c++) begin
      tick(1'b0, 1'b0, 8'h00);
      checks++;
      if (obs_valid !== 1'b1 || obs_pc !== 8'h00 || obs_instr !== 32'h00600113) begin
        errors++;
        $display("[TB] FAIL stall_hold_c%0d: got valid=%0b pc=%h instr=%h, expected valid=1 pc=00 instr=00600113",
                 c, obs_valid, obs_pc, obs_instr);
      end
    end
    checks++;
    if (obs_addr !== 8'h08) begin
      errors++;
      $display("[TB] FAIL stall_no_issue: got addr=%h, expected 08", obs_addr);
    end
    for (int i = 0; i < 3; i++) begin
      logic [7:0] e;
      e = 8'(4 * i);
      tick(1'b1, 1'b0, 8'h00);
      checks++;
      if (obs_valid !== 1'b1 || obs_pc !== e || obs_instr !== word_at(e)) begin
        errors++;
        $display("[TB] FAIL stall_drain%0d: got valid=%0b pc=%h instr=%h, expected valid=1 pc=%h instr=%h",
                 i, obs_valid, obs_pc, obs_instr, e, word_at(e));
      end
    end
  endtask

  // Redirect while one word is buffered and one is in flight.
  task automatic test_redirect_flush;
    restart(1'b0);
    tick(1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 8'h40);
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 8'h00);
    checks++;
    if (obs_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL redir_gap: got valid=%0b pc=%h, expected valid=0", obs_valid, obs_pc);
    end
    for (int i = 0; i < 3; i++) begin
      logic [7:0] e;
      e = 8'(8'h40 + 4 * i);
      tick(1'b1, 1'b0, 8'h00);
      checks++;
      if (obs_valid !== 1'b1 || obs_pc !== e || obs_instr !== word_at(e)) begin
        errors++;
        $display("[TB] FAIL redir_target%0d: got valid=%0b pc=%h instr=%h, expected valid=1 pc=%h instr=%h",
                 i, obs_valid, obs_pc, obs_instr, e, word_at(e));
      end
    end
  endtask

  // Redirect coinciding with a pop; the popped word counts as delivered.
  task automatic test_redirect_pop;
    restart(1'b1);
    repeat (3) tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b1, 8'h43);
    checks++;
    if (obs_valid !== 1'b1 || obs_pc !== 8'h08) begin
      errors++;
      $display("[TB] FAIL rpop_popped: got valid=%0b pc=%h, expected valid=1 pc=08", obs_valid, obs_pc);
    end
    for (int c = 1; c <= 2; c++) begin
      tick(1'b1, 1'b0, 8'h00);
      checks++;
      if (obs_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rpop_gap%0d: got valid=%0b pc=%h, expected valid=0", c, obs_valid, obs_pc);
      end
    end
    tick(1'b1, 1'b0, 8'h00);
    checks++;
    if (obs_valid !== 1'b1 || obs_pc !== 8'h40 || obs_instr !== word_at(8'h40)) begin
      errors++;
      $display("[TB] FAIL rpop_target: got valid=%0b pc=%h instr=%h, expected valid=1 pc=40 instr=%h",
               obs_valid, obs_pc, obs_instr, word_at(8'h40));
    end
  endtask

  // PC wraps modulo 256.
  task automatic test_wrap;
    int got;
    logic [7:0] e;
    restart(1'b1);
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b1, 8'hF8);
    got = 0;
    e   = 8'hF8;
    for (int c = 0; c < 12 && got < 4; c++) begin
      tick(1'b1, 1'b0, 8'h00);
      if (obs_valid) begin
        checks++;
        if (obs_pc !== e || obs_instr !== word_at(e)) begin
          errors++;
          $display("[TB] FAIL wrap_seq%0d: got pc=%h instr=%h, expected pc=%h instr=%h",
                   got, obs_pc, obs_instr, e, word_at(e));
        end
        e = e + 8'd4;
        got++;
      end
    end
    checks++;
    if (got != 4) begin
      errors++;
      $display("[TB] FAIL wrap_timeout: got %0d deliveries, expected 4", got);
    end
  endtask

  // Two consecutive redirects: only the second target is fetched.
  task automatic test_back_to_back;
    restart(1'b1);
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b1, 8'h20);
    tick(1'b1, 1'b1, 8'h80);
    tick(1'b1, 1'b0, 8'h00);
    checks++;
    if (obs_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_gap1: got valid=%0b pc=%h, expected valid=0", obs_valid, obs_pc);
    end
    tick(1'b1, 1'b0, 8'h00);
    checks++;
    if (obs_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_gap2: got valid=%0b pc=%h, expected valid=0", obs_valid, obs_pc);
    end
    for (int i = 0; i < 2; i++) begin
      logic [7:0] e;
      e = 8'(8'h80 + 4 * i);
      tick(1'b1, 1'b0, 8'h00);
      checks++;
      if (obs_valid !== 1'b1 || obs_pc !== e || obs_instr !== word_at(e)) begin
        errors++;
        $display("[TB] FAIL b2b_target%0d: got valid=%0b pc=%h instr=%h, expected valid=1 pc=%h instr=%h",
                 i, obs_valid, obs_pc, obs_instr, e, word_at(e));
      end
    end
  endtask

  // Asynchronous reset between clock edges while streaming.
  task automatic test_reset_mid;
    restart(1'b1);
    repeat (6) tick(1'b1, 1'b0, 8'h00);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 8'h00 || out_pc !== 8'h00 || out_instr !== 32'h0) begin
      errors++;
      $display("[TB] FAIL rstmid_immediate: got valid=%0b addr=%h pc=%h instr=%h, expected 0/00/00/00000000",
               out_valid, imem_addr, out_pc, out_instr);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick(1'b1, 1'b0, 8'h00);
    checks++;
    if (obs_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rstmid_c1: got valid=%0b, expected 0", obs_valid);
    end
    tick(1'b1, 1'b0, 8'h00);
    checks++;
    if (obs_valid !== 1'b1 || obs_pc !== 8'h00 || obs_instr !== 32'h00600113) begin
      errors++;
      $display("[TB] FAIL rstmid_restart: got valid=%0b pc=%h instr=%h, expected valid=1 pc=00 instr=00600113",
               obs_valid, obs_pc, obs_instr);
    end
  endtask

  // Random ready and redirect traffic against the delivery-order model.
  task automatic test_random;
    logic [7:0]  exp_pc;
    logic        rdy;
    logic        rv;
    logic [7:0]  rp;
    logic        prev_valid;
    logic        prev_hold;
    logic [7:0]  prev_pc;
    logic [31:0] prev_instr;
    int          delivered;
    restart(1'b1);
    exp_pc     = 8'h00;
    prev_valid = 1'b0;
    prev_hold  = 1'b0;
    prev_pc    = 8'h00;
    prev_instr = 32'h0;
    delivered  = 0;
    for (int c = 0; c < 600; c++) begin
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 24) == 0);
      rp  = 8'($urandom);
      tick(rdy, rv, rp);
      if (prev_valid && prev_hold) begin
        checks++;
        if (obs_valid !== 1'b1 || obs_pc !== prev_pc || obs_instr !== prev_instr) begin
          errors++;
          $display("[TB] FAIL rand_stall_c%0d: got valid=%0b pc=%h instr=%h, expected valid=1 pc=%h instr=%h",
                   c, obs_valid, obs_pc, obs_instr, prev_pc, prev_instr);
        end
      end
      if (obs_valid && rdy) begin
        checks++;
        if (obs_pc !== exp_pc || obs_instr !== word_at(exp_pc)) begin
          errors++;
          $display("[TB] FAIL rand_deliver_c%0d: got pc=%h instr=%h, expected pc=%h instr=%h",
                   c, obs_pc, obs_instr, exp_pc, word_at(exp_pc));
        end
        exp_pc = exp_pc + 8'd4;
        delivered++;
      end
      if (rv) exp_pc = {rp[7:2], 2'b00};
      prev_valid = obs_valid;
      prev_hold  = !rdy && !rv;
      prev_pc    = obs_pc;
      prev_instr = obs_instr;
    end
    checks++;
    if (delivered < 100) begin
      errors++;
      $display("[TB] FAIL rand_liveness: got %0d deliveries, expected at least 100", delivered);
    end
  endtask

  // Global time limit so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h00600113;
    mem[1] = 32'h00f00193;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_flush();
    test_redirect_pop();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
